mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single data-memory/IO bus (address decoder, data RAM, IO ports) between the
//   CPU and the debug monitor. Two-way round-robin arbiter with a req/ack handshake per
//   access, a latched transaction buffer and a read-latency counter. Sits between both
//   requesters and the address decoder; bus_* outputs drive the decoder's we/addr inputs.
// PARAMETERS
//   ADDR_W    32  address width of all ports
//   DATA_W    32  data width of all ports
//   READ_LAT  1   cycles from bus_addr valid to bus_rd valid (0..7)
// PORTS
//   clk       in   1       single clock, all state on rising edge
//   reset     in   1       synchronous, active-high
//   cpu_req   in   1       CPU access request, held until cpu_ack
//   cpu_we    in   1       1 = write, 0 = read
//   cpu_addr  in   ADDR_W  byte address
//   cpu_wd    in   DATA_W  write data
//   cpu_ack   out  1       one-cycle completion pulse
//   cpu_rd    out  DATA_W  read data, valid with cpu_ack, held until next CPU read
//   mon_req / mon_we / mon_addr / mon_wd / mon_ack / mon_rd : monitor copies of the above
//   bus_we    out  1       write strobe to address decoder
//   bus_addr  out  ADDR_W  address to decoder / RAM / IO
//   bus_wd    out  DATA_W  write data to RAM / IO
//   bus_rd    in   DATA_W  read data from RAM / IO read mux
//   busy      out  1       1 whenever state != IDLE
// BEHAVIOUR
//   - Clock clk, synchronous active-high reset. Reset: state IDLE, all outputs 0, cpu_rd and
//     mon_rd 0, last_grant = MON (first tie goes to CPU), latency counter 0.
//   - FSM IDLE -> GRANT -> [WAIT x READ_LAT, reads only] -> ACK -> IDLE.
//   - IDLE: if any req, pick winner (CPU-only, MON-only, or both -> the one != last_grant);
//     latch winner's we/addr/wd and id, update last_grant, go GRANT. No req: stay IDLE.
//   - GRANT (1 cycle): bus_addr/bus_wd = latched values; bus_we = latched we.
//     Write -> ACK. Read, READ_LAT=0 -> capture bus_rd, go ACK; else load counter, go WAIT.
//   - WAIT: bus_addr held, bus_we 0; counter decrements; at count 1 capture bus_rd -> ACK.
//   - ACK (1 cycle): winner's ack = 1; on read, winner's rd register updated from capture;
//     loser's ack and rd unchanged; bus_we 0. Next state IDLE unconditionally.
//   - Access latency req->ack: write 3 cycles (IDLE,GRANT,ACK); read 3 + READ_LAT.
//     Back-to-back service of two requesters: one IDLE cycle between transactions.
//   - Requester must hold req/we/addr/wd stable until ack and drop req the cycle after ack;
//     req still high in the IDLE after ack is a new request.
//   - req dropped mid-transaction: transaction completes, ack still pulsed (no abort).
//   - Other requester's req arriving mid-transaction: waits; not sampled until IDLE.
//   - bus_addr/bus_wd = 0 in IDLE and ACK; bus_we high only in GRANT of a write.
//   - Reset mid-transaction: next cycle IDLE, bus_we 0, no ack issued, rd registers 0.
//   - No arithmetic beyond 3-bit down-counter; addresses passed through unmodified.
// STRUCTURE
//   - Shared include mem_bus_defs.vh: state encodings (ST_IDLE/ST_GRANT/ST_WAIT/ST_ACK),
//     requester ids (ID_CPU=0, ID_MON=1).
//   - Sub-module rr_arbiter2: 2-way round-robin picker (req[1:0], update, gnt_id, last_grant
//     flop, resets to ID_MON). Top holds FSM, transaction latch, counter, rd registers.
// TESTING
//   1 CPU write 0x0000_1004 <= 0xDEADBEEF -> bus_we=1 one cycle in GRANT, cpu_ack 2 cycles
//     after req, mon_ack never.
//   2 MON read 0x0000_2008, READ_LAT=1, bus_rd=0x5A -> mon_ack at cycle 4, mon_rd=0x5A,
//     cpu_rd unchanged.
//   3 CPU and MON req same cycle after reset -> CPU served first, MON next; repeat both ->
//     alternate CPU/MON/CPU/MON.
//   4 CPU holds req continuously, MON requests once -> MON granted at next IDLE, no starvation.
//   5 reset asserted during WAIT of MON read -> next cycle busy=0, bus_we=0, no mon_ack,
//     mon_rd=0.
//   6 READ_LAT=0 and READ_LAT=3 builds: read ack latency 3 and 6 cycles, data matches bus_rd.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU / debug-monitor data bus arbiter.
// Holds the FSM state encoding, requester ids and the round-robin pick rule.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } bus_state_t;

   typedef enum logic {
      ID_CPU = 1'b0,
      ID_MON = 1'b1
   } req_id_t;

   localparam int CNT_W = 3;

   // On a tie the requester that was not served last wins.
   function automatic req_id_t rr_pick(input logic [1:0] req, input req_id_t last_grant);
      req_id_t pick;
      pick = ID_CPU;
      case (req)
         2'b10:   pick = ID_MON;
         2'b11:   pick = (last_grant == ID_CPU) ? ID_MON : ID_CPU;
         default: pick = ID_CPU;
      endcase
      return pick;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: combinational winner, registered last-grant history.
module mem_bus_arbiter_rr_arbiter2
   import mem_bus_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic       any_req,
   output req_id_t    gnt_id
);

   req_id_t last_grant;

   assign any_req = |req;
   assign gnt_id  = rr_pick(req, last_grant);

   // History starts at MON so the very first tie goes to the CPU.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= ID_MON;
      end else if (update && any_req) begin
         last_grant <= gnt_id;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-memory/IO bus between the CPU and the debug monitor, one
// req/ack transaction at a time, with a fixed read latency counted in WAIT.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int READ_LAT = 1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wd,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rd,
   input  logic              mon_req,
   input  logic              mon_we,
   input  logic [ADDR_W-1:0] mon_addr,
   input  logic [DATA_W-1:0] mon_wd,
   output logic              mon_ack,
   output logic [DATA_W-1:0] mon_rd,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wd,
   input  logic [DATA_W-1:0] bus_rd,
   output logic              busy
);

   localparam logic [CNT_W-1:0] LAT = CNT_W'(READ_LAT);

   bus_state_t        state;
   req_id_t           gnt_id;
   req_id_t           txn_id;
   logic              txn_we;
   logic [CNT_W-1:0]  lat_cnt;
   logic              any_req;
   logic              arb_update;
   logic              complete;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wd;

   mem_bus_arbiter_rr_arbiter2 u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     ({mon_req, cpu_req}),
      .update  (arb_update),
      .any_req (any_req),
      .gnt_id  (gnt_id)
   );

   assign arb_update = (state == ST_IDLE) && any_req;
   assign busy       = (state != ST_IDLE);

   // The transaction finishes on the edge that moves the FSM into ACK.
   assign complete = ((state == ST_GRANT) && (txn_we || (LAT == '0))) ||
                     ((state == ST_WAIT)  && (lat_cnt == CNT_W'(1)));

   always_comb begin
      win_we   = cpu_we;
      win_addr = cpu_addr;
      win_wd   = cpu_wd;
      if (gnt_id == ID_MON) begin
         win_we   = mon_we;
         win_addr = mon_addr;
         win_wd   = mon_wd;
      end
   end

   // Bus outputs are registered so they follow the state they belong to exactly;
   // read data is captured straight into the winner's rd register on completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         txn_id   <= ID_CPU;
         txn_we   <= 1'b0;
         lat_cnt  <= '0;
         bus_we   <= 1'b0;
         bus_addr <= '0;
         bus_wd   <= '0;
         cpu_ack  <= 1'b0;
         mon_ack  <= 1'b0;
         cpu_rd   <= '0;
         mon_rd   <= '0;
      end else begin
         bus_we  <= 1'b0;
         cpu_ack <= 1'b0;
         mon_ack <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (any_req) begin
                  txn_id   <= gnt_id;
                  txn_we   <= win_we;
                  bus_we   <= win_we;
                  bus_addr <= win_addr;
                  bus_wd   <= win_wd;
                  state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (txn_we || (LAT == '0)) begin
                  state <= ST_ACK;
               end else begin
                  lat_cnt <= LAT;
                  state   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == CNT_W'(1)) begin
                  state <= ST_ACK;
               end
            end
            ST_ACK: begin
               state <= ST_IDLE;
            end
         endcase

         if (complete) begin
            bus_addr <= '0;
            bus_wd   <= '0;
            if (txn_id == ID_CPU) begin
               cpu_ack <= 1'b1;
               if (!txn_we) begin
                  cpu_rd <= bus_rd;
               end
            end else begin
               mon_ack <= 1'b1;
               if (!txn_we) begin
                  mon_rd <= bus_rd;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration order and access latency.
module tb_mem_bus_arbiter;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_ack;
   logic [31:0] cpu_addr, cpu_wd, cpu_rd;
   logic        mon_req, mon_we, mon_ack;
   logic [31:0] mon_addr, mon_wd, mon_rd;
   logic        bus_we, busy;
   logic [31:0] bus_addr, bus_wd;
   logic [31:0] bus_rd = '0;

   logic        v0_cpu_ack, v0_mon_ack, v0_bus_we, v0_busy;
   logic [31:0] v0_cpu_rd, v0_mon_rd, v0_bus_addr, v0_bus_wd, v0_bus_rd;
   logic        v3_cpu_ack, v3_mon_ack, v3_bus_we, v3_busy;
   logic [31:0] v3_cpu_rd, v3_mon_rd, v3_bus_addr, v3_bus_wd, v3_bus_rd;

   int vectors     = 0;
   int miscompares = 0;
   int age         = 0;
   logic [31:0] seen_addr = '0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_ack(cpu_ack), .cpu_rd(cpu_rd),
      .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wd(mon_wd),
      .mon_ack(mon_ack), .mon_rd(mon_rd),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_rd(bus_rd), .busy(busy)
   );

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(0)) dut_lat0 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_ack(v0_cpu_ack), .cpu_rd(v0_cpu_rd),
      .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wd(mon_wd),
      .mon_ack(v0_mon_ack), .mon_rd(v0_mon_rd),
      .bus_we(v0_bus_we), .bus_addr(v0_bus_addr), .bus_wd(v0_bus_wd), .bus_rd(v0_bus_rd),
      .busy(v0_busy)
   );

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) dut_lat3 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_ack(v3_cpu_ack), .cpu_rd(v3_cpu_rd),
      .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wd(mon_wd),
      .mon_ack(v3_mon_ack), .mon_rd(v3_mon_rd),
      .bus_we(v3_bus_we), .bus_addr(v3_bus_addr), .bus_wd(v3_bus_wd), .bus_rd(v3_bus_rd),
      .busy(v3_busy)
   );

   assign v0_bus_rd = mem_val(v0_bus_addr);
   assign v3_bus_rd = mem_val(v3_bus_addr);

   // Memory whose data is only correct exactly LAT cycles after the address appears.
   always @(negedge clk) begin
      if (bus_addr != seen_addr) age = 0;
      else age = age + 1;
      seen_addr = bus_addr;
      bus_rd = (bus_addr != '0 && age == LAT) ? mem_val(bus_addr) : ~mem_val(bus_addr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      cpu_req  = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
      mon_req  = 1'b0; mon_we = 1'b0; mon_addr = '0; mon_wd = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic new_req(input int r);
      if (r == 0) begin
         cpu_req  = 1'b1;
         cpu_we   = 1'($urandom_range(0, 1));
         cpu_addr = $urandom | 32'h4;
         cpu_wd   = $urandom;
      end else begin
         mon_req  = 1'b1;
         mon_we   = 1'($urandom_range(0, 1));
         mon_addr = $urandom | 32'h4;
         mon_wd   = $urandom;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'h1;
      mon_req = 1'b1; mon_we = 1'b0; mon_addr = 32'h20; mon_wd = 32'h2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, bus_we, cpu_ack, mon_ack} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl got %b exp 0000", {busy, bus_we, cpu_ack, mon_ack});
      end
      vectors++;
      if (bus_addr !== 32'h0 || bus_wd !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_bus got addr %h wd %h exp 0", bus_addr, bus_wd);
      end
      vectors++;
      if (cpu_rd !== 32'h0 || mon_rd !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_rd got cpu %h mon %h exp 0", cpu_rd, mon_rd);
      end
      do_reset();
   endtask

   task automatic test_cpu_write();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1004; cpu_wd = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++;
         if (bus_we !== (c == 1)) begin
            miscompares++;
            $display("[TB] FAIL wr_bus_we c=%0d got %b exp %b", c, bus_we, (c == 1));
         end
         vectors++;
         if (cpu_ack !== (c == 2) || mon_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wr_ack c=%0d got cpu %b mon %b exp cpu %b mon 0", c, cpu_ack, mon_ack, (c == 2));
         end
         vectors++;
         if (bus_addr !== ((c == 1) ? 32'h0000_1004 : 32'h0) || bus_wd !== ((c == 1) ? 32'hDEAD_BEEF : 32'h0)) begin
            miscompares++;
            $display("[TB] FAIL wr_bus c=%0d got addr %h wd %h", c, bus_addr, bus_wd);
         end
         vectors++;
         if (busy !== (c == 1 || c == 2)) begin
            miscompares++;
            $display("[TB] FAIL wr_busy c=%0d got %b exp %b", c, busy, (c == 1 || c == 2));
         end
         tick();
         if (c == 2) cpu_req = 1'b0;
      end
      do_reset();
   endtask

   task automatic test_mon_read();
      mon_req = 1'b1; mon_we = 1'b0; mon_addr = 32'h0000_2008; mon_wd = $urandom;
      for (int c = 0; c < 4 + LAT; c++) begin
         @(negedge clk);
         vectors++;
         if (mon_ack !== (c == 2 + LAT) || cpu_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_ack c=%0d got mon %b cpu %b exp mon %b", c, mon_ack, cpu_ack, (c == 2 + LAT));
         end
         vectors++;
         if (bus_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_bus_we c=%0d got %b exp 0", c, bus_we);
         end
         if (c == 2 + LAT) begin
            vectors++;
            if (mon_rd !== mem_val(32'h0000_2008) || cpu_rd !== 32'h0) begin
               miscompares++;
               $display("[TB] FAIL rd_data got mon %h cpu %h exp mon %h cpu 0", mon_rd, cpu_rd, mem_val(32'h0000_2008));
            end
         end
         tick();
         if (c == 2 + LAT) mon_req = 1'b0;
      end
      do_reset();
   endtask

   task automatic test_tie_alternate();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0100; cpu_wd = $urandom;
      mon_req = 1'b1; mon_we = 1'b1; mon_addr = 32'h0000_0200; mon_wd = $urandom;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         vectors++;
         if (cpu_ack !== (c == 2 || c == 8) || mon_ack !== (c == 5 || c == 11)) begin
            miscompares++;
            $display("[TB] FAIL tie_order c=%0d got cpu %b mon %b", c, cpu_ack, mon_ack);
         end
         if (c == 1 || c == 7 || c == 4 || c == 10) begin
            vectors++;
            if (bus_addr !== ((c == 1 || c == 7) ? 32'h0000_0100 : 32'h0000_0200)) begin
               miscompares++;
               $display("[TB] FAIL tie_addr c=%0d got %h", c, bus_addr);
            end
         end
         tick();
      end
      do_reset();
   endtask

   task automatic test_no_starvation();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0300; cpu_wd = $urandom;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         vectors++;
         if (cpu_ack !== (c == 2 || c == 8 || c == 11) || mon_ack !== (c == 5)) begin
            miscompares++;
            $display("[TB] FAIL starve c=%0d got cpu %b mon %b", c, cpu_ack, mon_ack);
         end
         tick();
         if (c == 0) begin
            mon_req = 1'b1; mon_we = 1'b1; mon_addr = 32'h0000_0400; mon_wd = $urandom;
         end
         if (c == 5) mon_req = 1'b0;
      end
      do_reset();
   endtask

   task automatic test_reset_mid_wait();
      mon_req = 1'b1; mon_we = 1'b0; mon_addr = 32'h0000_0500;
      repeat (3 + LAT) tick();
      mon_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (mon_rd !== mem_val(32'h0000_0500)) begin
         miscompares++;
         $display("[TB] FAIL rm_first got %h exp %h", mon_rd, mem_val(32'h0000_0500));
      end
      tick();
      mon_req = 1'b1; mon_addr = 32'h0000_0600;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; mon_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({busy, bus_we, mon_ack} !== 3'b000 || mon_rd !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL rm_after c=%0d got busy %b we %b ack %b rd %h exp 0", c, busy, bus_we, mon_ack, mon_rd);
         end
         tick();
      end
      do_reset();
   endtask

   task automatic test_latency_variants();
      logic [31:0] a;
      a = $urandom | 32'h4;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         vectors++;
         if (v0_cpu_ack !== (c == 2) || v3_cpu_ack !== (c == 5)) begin
            miscompares++;
            $display("[TB] FAIL lat_ack c=%0d got lat0 %b lat3 %b", c, v0_cpu_ack, v3_cpu_ack);
         end
         if (c == 2) begin
            vectors++;
            if (v0_cpu_rd !== mem_val(a)) begin
               miscompares++;
               $display("[TB] FAIL lat0_data got %h exp %h", v0_cpu_rd, mem_val(a));
            end
         end
         if (c == 5) begin
            vectors++;
            if (v3_cpu_rd !== mem_val(a) || v3_mon_ack !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL lat3_data got %h exp %h", v3_cpu_rd, mem_val(a));
            end
         end
         tick();
         if (c == 1) cpu_req = 1'b0;
      end
      do_reset();
   endtask

   // Transaction-level model: bus free/occupied windows, round-robin on ties,
   // write takes 3 cycles and read 3 + LAT from the deciding IDLE cycle.
   task automatic test_random(input int ncycles);
      logic [1:0]  rq, ack_now, ack_prev;
      logic [31:0] exp_rd [2];
      logic [31:0] s_addr, s_wd, exp_addr;
      logic        act, s_we;
      int          start, dur, id, last;
      rq = 2'b00; ack_prev = 2'b00; exp_rd[0] = '0; exp_rd[1] = '0;
      act = 1'b0; start = 0; dur = 0; id = 0; last = 1;
      s_addr = '0; s_wd = '0; s_we = 1'b0;
      for (int k = 0; k < ncycles; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (rq[r] && ack_prev[r]) begin
               if ($urandom_range(0, 3) == 0) new_req(r);
               else begin
                  rq[r] = 1'b0;
                  if (r == 0) cpu_req = 1'b0; else mon_req = 1'b0;
               end
            end else if (!rq[r] && $urandom_range(0, 2) == 0) begin
               rq[r] = 1'b1;
               new_req(r);
            end
         end
         if (act && k >= start + dur) act = 1'b0;
         if (!act && rq != 2'b00) begin
            if (rq == 2'b11) id = 1 - last;
            else id = rq[0] ? 0 : 1;
            last   = id;
            act    = 1'b1;
            start  = k;
            s_we   = (id == 0) ? cpu_we : mon_we;
            s_addr = (id == 0) ? cpu_addr : mon_addr;
            s_wd   = (id == 0) ? cpu_wd : mon_wd;
            dur    = s_we ? 3 : 3 + LAT;
         end
         ack_now = 2'b00;
         if (act && k == start + dur - 1) begin
            ack_now[id] = 1'b1;
            if (!s_we) exp_rd[id] = mem_val(s_addr);
         end
         exp_addr = (act && k > start && k < start + dur - 1) ? s_addr : 32'h0;
         @(negedge clk);
         vectors++;
         if (cpu_ack !== ack_now[0] || mon_ack !== ack_now[1]) begin
            miscompares++;
            $display("[TB] FAIL rnd_ack k=%0d got cpu %b mon %b exp %b %b", k, cpu_ack, mon_ack, ack_now[0], ack_now[1]);
         end
         vectors++;
         if (busy !== (act && k > start) || bus_we !== (act && s_we && k == start + 1)) begin
            miscompares++;
            $display("[TB] FAIL rnd_ctrl k=%0d got busy %b we %b", k, busy, bus_we);
         end
         vectors++;
         if (bus_addr !== exp_addr) begin
            miscompares++;
            $display("[TB] FAIL rnd_addr k=%0d got %h exp %h", k, bus_addr, exp_addr);
         end
         if (act && k == start + 1) begin
            vectors++;
            if (bus_wd !== s_wd) begin
               miscompares++;
               $display("[TB] FAIL rnd_wd k=%0d got %h exp %h", k, bus_wd, s_wd);
            end
         end
         vectors++;
         if (cpu_rd !== exp_rd[0] || mon_rd !== exp_rd[1]) begin
            miscompares++;
            $display("[TB] FAIL rnd_rd k=%0d got cpu %h mon %h exp %h %h", k, cpu_rd, mon_rd, exp_rd[0], exp_rd[1]);
         end
         ack_prev = ack_now;
         tick();
      end
      do_reset();
   endtask

   initial begin
      do_reset();
      test_reset();
      test_cpu_write();
      test_mon_read();
      test_tie_alternate();
      test_no_starvation();
      test_reset_mid_wait();
      test_latency_variants();
      test_random(800);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
